// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// start/div_op/div_op1/div_op2/flush are sampled on the rising edge; done is a one-cycle valid pulse for div_out.
interface div_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 2
);
  logic                  start;
  logic [OP_WIDTH-1:0]   div_op;
  logic [DATA_WIDTH-1:0] div_op1;
  logic [DATA_WIDTH-1:0] div_op2;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] div_out;
  logic [1:0]            dbg_state;

  modport master (
    output start, div_op, div_op1, div_op2, flush,
    input  busy, done, div_out, dbg_state
  );

  modport slave (
    input  start, div_op, div_op1, div_op2, flush,
    output busy, done, div_out, dbg_state
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// divide-by-zero and signed-overflow cases resolved in a single cycle.
module div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 2
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  is_rem_q, is_rem_d;

  logic                  op_signed, op_rem, a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH+1:0] shifted;
  logic [DATA_WIDTH+1:0] dvsr_ext;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    out_d     = out_q;
    count_d   = count_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;

    op_signed = ~bus.div_op[0];
    op_rem    = bus.div_op[1];
    a_neg     = op_signed & bus.div_op1[DATA_WIDTH-1];
    b_neg     = op_signed & bus.div_op2[DATA_WIDTH-1];
    a_mag     = a_neg ? -bus.div_op1 : bus.div_op1;
    b_mag     = b_neg ? -bus.div_op2 : bus.div_op2;

    // Partial remainder shifted left with the next dividend bit; kept one bit wider so the compare is exact.
    shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
    dvsr_ext  = {2'b00, dvsr_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          if (bus.div_op2 == '0) begin
            out_d   = op_rem ? bus.div_op1 : '1;
            state_d = S_DONE;
          end else if (op_signed && bus.div_op1 == MIN_NEG && bus.div_op2 == '1) begin
            out_d   = op_rem ? '0 : MIN_NEG;
            state_d = S_DONE;
          end else begin
            quo_d     = a_mag;
            dvsr_d    = b_mag;
            rem_d     = '0;
            count_d   = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            is_rem_d  = op_rem;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (shifted >= dvsr_ext) begin
          rem_d = (DATA_WIDTH+1)'(shifted - dvsr_ext);
          quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[DATA_WIDTH:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(DATA_WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_rem_q) out_d = neg_rem_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
        else          out_d = neg_quo_q ? -quo_q : quo_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any request in the same cycle and leaves the last result visible.
    if (bus.flush) begin
      state_d = S_IDLE;
      out_d   = out_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      out_q     <= '0;
      count_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      out_q     <= out_d;
      count_q   <= count_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

  assign bus.busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.done      = (state_q == S_DONE);
  assign bus.div_out   = out_q;
  assign bus.dbg_state = state_q;
endmodule
